// File: rtl/fp_issue_ctrl.sv
// rtl/fp_issue_ctrl.sv - FP request sequencer between decode and the FPU
// Holds operands for the FPU, waits for the result (with watchdog) and issues a one-cycle writeback.
module fp_issue_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [31:0] NAN_VAL = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic [1:0]  fpu_op,
  output logic        fpu_vld,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_res,
  input  logic        fpu_res_vld,
  input  logic        fpu_exception,
  input  logic        fpu_overflow,
  input  logic        fpu_underflow,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic [3:0]  fflags,
  input  logic        flags_clr
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  rd_q;
  logic [7:0]  wdog;
  logic [31:0] wb_data_q;
  logic [3:0]  lat_flags;
  logic [3:0]  fflags_q;
  logic [3:0]  wb_flags;
  logic [3:0]  fflags_nxt;
  logic        accept;
  logic        wdog_expired;

  assign accept       = (state == S_IDLE) && req_vld;
  assign wdog_expired = (wdog == WDOG_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_vld) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (fpu_res_vld || wdog_expired) state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_rdy = 1'b0;
    fpu_vld = 1'b0;
    busy    = 1'b1;
    wb_en   = 1'b0;
    case (state)
      S_IDLE: begin
        req_rdy = 1'b1;
        busy    = 1'b0;
      end
      S_ISSUE: fpu_vld = 1'b1;
      S_WB:    wb_en = 1'b1;
      default: ;
    endcase
  end

  // A flag arriving in the WB cycle survives a simultaneous clear.
  assign wb_flags   = (state == S_WB) ? lat_flags : 4'b0000;
  assign fflags_nxt = flags_clr ? wb_flags : (fflags_q | wb_flags);

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      wdog      <= '0;
      wb_data_q <= '0;
      lat_flags <= '0;
      fflags_q  <= '0;
    end else begin
      if (accept) begin
        op_q <= req_op;
        a_q  <= req_a;
        b_q  <= req_b;
        rd_q <= req_rd;
      end
      case (state)
        S_ISSUE: wdog <= '0;
        S_WAIT: begin
          wdog <= wdog + 8'd1;
          if (fpu_res_vld) begin
            wb_data_q <= fpu_res;
            lat_flags <= {1'b0, fpu_exception, fpu_overflow, fpu_underflow};
          end else if (wdog_expired) begin
            wb_data_q <= NAN_VAL;
            lat_flags <= 4'b1000;
          end
        end
        default: ;
      endcase
      fflags_q <= fflags_nxt;
    end
  end

  assign fpu_op  = op_q;
  assign fpu_a   = a_q;
  assign fpu_b   = b_q;
  assign wb_rd   = rd_q;
  assign wb_data = wb_data_q;
  assign fflags  = fflags_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb/tb_fp_issue_ctrl.sv - self-checking bench for fp_issue_ctrl
// Directed vector table, hand-written reset/clear sequences and randomized requests with an FPU stub.
module tb_fp_issue_ctrl;

  localparam int          TO  = 16;
  localparam logic [31:0] NAN = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld;
  logic        req_rdy;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic [1:0]  fpu_op;
  logic        fpu_vld;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [31:0] fpu_res;
  logic        fpu_res_vld;
  logic        fpu_exception;
  logic        fpu_overflow;
  logic        fpu_underflow;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic [3:0]  fflags;
  logic        flags_clr;

  always #5 clk = ~clk;

  fp_issue_ctrl #(.TIMEOUT(TO), .NAN_VAL(NAN)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .fpu_op(fpu_op), .fpu_vld(fpu_vld), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_res(fpu_res), .fpu_res_vld(fpu_res_vld),
    .fpu_exception(fpu_exception), .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .fflags(fflags), .flags_clr(flags_clr)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [2:0]  fl;
    logic        sup;
    logic        clr;
    logic        hold;
    int          exp_lat;
    logic [31:0] exp_data;
    logic [3:0]  exp_ff;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [31:0] plan_res;
  logic [2:0]  plan_fl;
  logic        plan_sup;
  logic [3:0]  model_ff;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic [31:0] res, input logic [2:0] fl,
                              input logic sup, input logic clr, input logic hold,
                              input int lat, input logic [31:0] data, input logic [3:0] ff);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.rd = rd; v.res = res; v.fl = fl;
    v.sup = sup; v.clr = clr; v.hold = hold;
    v.exp_lat = lat; v.exp_data = data; v.exp_ff = ff;
    return v;
  endfunction

  task automatic set_plan(input vec_t v);
    plan_res = v.res;
    plan_fl  = v.fl;
    plan_sup = v.sup;
  endtask

  task automatic apply(input vec_t v);
    req_vld = 1'b1;
    req_op  = v.op;
    req_a   = v.a;
    req_b   = v.b;
    req_rd  = v.rd;
  endtask

  // FPU stub: answers L cycles after the issue pulse (L=2 for mul); flags/result are noise otherwise.
  initial begin
    int          cnt;
    logic [31:0] r;
    logic [2:0]  f;
    logic        s;
    cnt = 0; r = '0; f = '0; s = 1'b0;
    fpu_res = '0; fpu_res_vld = 1'b0;
    fpu_exception = 1'b0; fpu_overflow = 1'b0; fpu_underflow = 1'b0;
    forever begin
      @(posedge clk); #1;
      fpu_res_vld = 1'b0;
      fpu_res = $urandom;
      {fpu_exception, fpu_overflow, fpu_underflow} = 3'($urandom_range(0, 7));
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !s) begin
          fpu_res_vld = 1'b1;
          fpu_res = r;
          {fpu_exception, fpu_overflow, fpu_underflow} = f;
        end
      end
      if (fpu_vld) begin
        cnt = (fpu_op == 2'b10) ? 2 : 1;
        r = plan_res; f = plan_fl; s = plan_sup;
      end
    end
  end

  // Entry at a negedge; b2b means the request is already presented and this cycle is its handshake.
  task automatic run_req(input vec_t v, input logic b2b, input vec_t nxt, input logic hold);
    int   n;
    int   lat;
    logic bad;
    if (!b2b) begin
      set_plan(v);
      @(posedge clk); #1;
      apply(v);
      @(negedge clk);
      n = 0;
      while (!req_rdy && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    chk("accept_rdy", req_rdy, 1);
    @(posedge clk); #1;
    if (hold) apply(nxt);
    else req_vld = 1'b0;
    @(negedge clk);
    chk("issue_vld", {fpu_vld, busy, req_rdy}, 3'b110);
    chk("issue_ops", {fpu_op, fpu_a, fpu_b, wb_en}, {v.op, v.a, v.b, 1'b0});
    lat = 1;
    bad = 1'b0;
    while (!wb_en && lat < 300) begin
      @(posedge clk); #1;
      flags_clr = v.clr && (lat + 1 == v.exp_lat);
      @(negedge clk);
      lat++;
      if (fpu_vld || req_rdy || !busy || fpu_op !== v.op || fpu_a !== v.a || fpu_b !== v.b) bad = 1'b1;
    end
    chk("latency", lat, v.exp_lat);
    chk("wb_rd", wb_rd, v.rd);
    chk("wb_data", wb_data, v.exp_data);
    chk("busy_hold", bad, 0);
    if (hold) set_plan(nxt);
    @(posedge clk); #1;
    flags_clr = 1'b0;
    @(negedge clk);
    chk("post_wb", {wb_en, busy, req_rdy, wb_data}, {1'b0, 1'b0, 1'b1, v.exp_data});
    chk("fflags", fflags, v.exp_ff);
    model_ff = v.exp_ff;
  endtask

  vec_t vt[8];

  initial begin
    vec_t v;
    vec_t nx;
    logic bad;
    rst = 1'b1; req_vld = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_rd = '0;
    flags_clr = 1'b0; model_ff = '0;
    plan_res = '0; plan_fl = '0; plan_sup = 1'b0;

    vt[0] = mk(2'b00, 32'h3F800000, 32'h40000000, 5'd5,  32'h40400000, 3'b000, 0, 0, 0, 3,    32'h40400000, 4'b0000);
    vt[1] = mk(2'b01, 32'h40400000, 32'h3F800000, 5'd7,  32'h40000000, 3'b000, 0, 0, 1, 3,    32'h40000000, 4'b0000);
    vt[2] = mk(2'b10, 32'h40000000, 32'h40400000, 5'd8,  32'h40C00000, 3'b000, 0, 0, 0, 4,    32'h40C00000, 4'b0000);
    vt[3] = mk(2'b10, 32'h7F000000, 32'h7F000000, 5'd9,  32'h7F800000, 3'b010, 0, 0, 0, 4,    32'h7F800000, 4'b0010);
    vt[4] = mk(2'b00, 32'h3F800000, 32'h3F800000, 5'd10, 32'h40000000, 3'b000, 0, 0, 0, 3,    32'h40000000, 4'b0010);
    vt[5] = mk(2'b00, 32'h3F800000, 32'h3F800000, 5'd11, 32'h40000000, 3'b000, 1, 0, 0, 2+TO, NAN,          4'b1010);
    vt[6] = mk(2'b10, 32'h7F000000, 32'h7F000000, 5'd12, 32'h7F800000, 3'b010, 0, 1, 0, 4,    32'h7F800000, 4'b0010);
    vt[7] = mk(2'b11, 32'hC0490FDB, 32'h00000000, 5'd31, 32'hC0490FDB, 3'b100, 0, 0, 0, 3,    32'hC0490FDB, 4'b0110);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ctl", {req_rdy, busy, fpu_vld, wb_en}, 4'b1000);
    chk("reset_dat", {fpu_op, fpu_a, wb_rd, fflags}, '0);
    chk("reset_dat2", {fpu_b, wb_data}, '0);

    for (int i = 0; i < 8; i++) begin
      nx = (i < 7) ? vt[i + 1] : vt[i];
      run_req(vt[i], (i > 0) && vt[(i > 0) ? i - 1 : 0].hold, nx, vt[i].hold);
    end

    @(posedge clk); #1 flags_clr = 1'b1;
    @(posedge clk); #1 flags_clr = 1'b0;
    @(negedge clk);
    chk("clr_idle", fflags, 4'b0000);
    model_ff = '0;

    for (int i = 0; i < 40; i++) begin
      v.op = 2'($urandom_range(0, 3));
      v.a = $urandom; v.b = $urandom; v.rd = 5'($urandom_range(0, 31));
      v.res = $urandom; v.fl = 3'($urandom_range(0, 7));
      v.sup = ($urandom_range(0, 9) == 0);
      v.clr = ($urandom_range(0, 3) == 0);
      v.hold = 1'b0;
      v.exp_lat  = v.sup ? 2 + TO : ((v.op == 2'b10) ? 4 : 3);
      v.exp_data = v.sup ? NAN : v.res;
      v.exp_ff   = (v.clr ? 4'b0000 : model_ff) | (v.sup ? 4'b1000 : {1'b0, v.fl});
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_req(v, 1'b0, v, 1'b0);
    end

    // Force a sticky flag so the reset clearing fflags is observable.
    v = mk(2'b00, 32'h1, 32'h2, 5'd4, 32'h3, 3'b001, 0, 0, 0, 3, 32'h3, model_ff | 4'b0001);
    run_req(v, 1'b0, v, 1'b0);

    v = mk(2'b10, 32'h40000000, 32'h40400000, 5'd3, 32'h12345678, 3'b111, 0, 0, 0, 4, 32'h12345678, 4'b0000);
    set_plan(v);
    @(posedge clk); #1 apply(v);
    @(negedge clk);
    chk("rst_accept", req_rdy, 1);
    @(posedge clk); #1 req_vld = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_in_wait", {busy, fpu_vld, wb_en}, 3'b100);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctl", {req_rdy, busy, fpu_vld, wb_en, fflags}, 8'b1000_0000);
    chk("rst_mid_dat", {fpu_op, fpu_a, fpu_b}, '0);
    chk("rst_mid_wb", {wb_rd, wb_data}, '0);
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (wb_en || busy || fflags != 4'b0000 || wb_data != 32'h0) bad = 1'b1;
    end
    chk("rst_late_res", bad, 0);
    model_ff = '0;

    run_req(vt[0], 1'b0, vt[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_issue_ctrl.md
Name: fp_issue_ctrl

Overview:
- Sequencer between the core's FP decode stage and the FP arithmetic unit (add/sub/mul/pass).
- Accepts one FP request via valid/ready, holds operands stable on the FPU input bus and pulses the FPU valid.
- Waits for the FPU result-valid, then issues a one-cycle register-file writeback and accumulates sticky status flags.
- Provides a watchdog so a lost result-valid cannot hang the core.

Parameters:
- TIMEOUT, 16: maximum cycles in WAIT before forced completion (range 2..255).
- NAN_VAL, 32'h7FC00000: writeback data on timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_vld  in  1  request valid
- req_rdy  out  1  request ready (high only in IDLE)
- req_op  in  2  00 add, 01 sub, 10 mul, 11 pass-A
- req_a  in  32  operand A (FP32)
- req_b  in  32  operand B (FP32)
- req_rd  in  5  destination FP register
- fpu_op  out  2  op to FPU
- fpu_vld  out  1  one-cycle issue pulse
- fpu_a  out  32  operand A to FPU
- fpu_b  out  32  operand B to FPU
- fpu_res  in  32  FPU result
- fpu_res_vld  in  1  FPU result valid
- fpu_exception  in  1  FPU exception flag
- fpu_overflow  in  1  FPU overflow flag
- fpu_underflow  in  1  FPU underflow flag
- wb_en  out  1  writeback strobe (one cycle)
- wb_rd  out  5  writeback register index
- wb_data  out  32  writeback data
- busy  out  1  high when not IDLE (core stall)
- fflags  out  4  sticky {timeout, exception, overflow, underflow}
- flags_clr  in  1  clear fflags

Behaviour:
- Reset: state IDLE. All outputs and internal registers are 0: fpu_op/a/b, fpu_vld, wb_*, fflags, watchdog. req_rdy=1 from the first cycle after reset. A reset in any state aborts the operation; no writeback occurs.
- IDLE: req_rdy=1, busy=0. When req_vld&req_rdy, capture op/a/b/rd into registers and go to ISSUE.
- ISSUE (one cycle): fpu_vld=1, busy=1; go to WAIT with watchdog=0.
- WAIT: fpu_vld=0 and busy=1; the watchdog increments each cycle.
  - When fpu_res_vld=1: capture fpu_res into wb_data and latch the three FPU flags; go to WB.
  - Else, when watchdog==TIMEOUT-1: wb_data=NAN_VAL, latch timeout=1 and the other flags 0; go to WB.
- WB (one cycle): wb_en=1, wb_rd=captured rd. fflags |= latched flags. Go to IDLE. wb_data holds its value after WB; wb_en=0 outside WB.
- fpu_op/fpu_a/fpu_b are driven from the capture registers. They stay stable from ISSUE through WB and are unchanged in IDLE until the next capture. FPU flags are combinational from these held operands and are sampled only in the fpu_res_vld cycle.
- fpu_res_vld outside WAIT is ignored; it has no effect on state or flags.
- Latency from the handshake cycle T0:
  - ISSUE at T1.
  - FPU result visible at T1+L, where L=1 for add/sub/pass and L=2 for mul.
  - wb_en at T2+L: T3 for add, T4 for mul.
- Throughput: one request per (3+L) cycles. req_rdy is low from the ISSUE cycle through the WB cycle.
- flags_clr: on a cycle with flags_clr=1, fflags_next = (WB ? latched flags : 0); new flags win over the clear. With flags_clr=0, fflags_next = fflags | (WB ? latched : 0).
- Watchdog is 8 bits wide and resets to 0 on entry to WAIT; it never wraps because the timeout fires first.
- req_vld while busy is not consumed; the requester must hold the request until req_rdy.

Test Plan:
- Add: req_op=00, a=32'h3F800000, b=32'h40000000, rd=5 at T0 -> fpu_vld pulse at T1; wb_en=1, wb_rd=5, wb_data=32'h40400000 at T3; fflags=0.
- Sub then mul back-to-back, req_vld held high:
  - 32'h40400000 − 32'h3F800000 -> wb_data 32'h40000000.
  - Next request accepted the cycle after WB; 32'h40000000 × 32'h40400000 -> wb_data 32'h40C00000, wb_en exactly 4 cycles after its handshake.
- Mul overflow: 32'h7F000000 × 32'h7F000000 -> wb_data 32'h7F800000, fflags=4'b0010 and still set after a following clean add.
- Timeout: FPU model suppresses fpu_res_vld, TIMEOUT=16 -> wb_en after 16 WAIT cycles, wb_data 32'h7FC00000, fflags[3]=1, then req_rdy=1.
- Reset mid-WAIT: assert rst for one cycle during WAIT -> no wb_en; all outputs 0; req_rdy=1 after reset; a late fpu_res_vld is ignored.
- flags_clr coincident with WB of an overflowing mul -> fflags=4'b0010, not 0. flags_clr alone in IDLE -> fflags=0.
